// File: rtl/sprite_line_loader_pkg.sv
// Shared types and helpers for the sprite line loader.
// Optional build macro SPR_SKIP_EN is honoured by sprite_line_loader.sv.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  localparam int SPR_MAX_NUM = 32;
  localparam int SPR_MAX_LAT = 4;

  function automatic int spr_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sprite_line_loader_if.sv
// Line-load control and sprite ROM address bundle.
// Master drives the line/mask/address inputs; slave is the loader.
interface sprite_line_loader_if #(
  parameter int NUM_SPR = 5,
  parameter int ADDR_W  = 9
);
  logic                      loading_loc;
  logic                      linebegin;
  logic [NUM_SPR-1:0]        spr_active;
  logic [NUM_SPR*ADDR_W-1:0] mem_addr_flat;
  logic [ADDR_W-1:0]         mem_addr_out;
  logic [NUM_SPR-1:0]        load_en;
  logic                      img_load_done;
  logic                      busy;

  modport master (
    output loading_loc, linebegin,
    output spr_active, mem_addr_flat,
    input  mem_addr_out, load_en,
    input  img_load_done, busy
  );

  modport slave (
    input  loading_loc, linebegin,
    input  spr_active, mem_addr_flat,
    output mem_addr_out, load_en,
    output img_load_done, busy
  );
endinterface

// File: rtl/sprite_line_loader_lat_pipe.sv
// ROM latency pipe: occupancy, load-enable and sprite index per stage.
// Occupancy drives the empty flag so masked slots still hold off done.
module spr_lat_pipe #(
  parameter int LAT = 1,
  parameter int IW  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_v,
  input  logic          in_en,
  input  logic [IW-1:0] in_idx,
  output logic          out_v,
  output logic          out_en,
  output logic [IW-1:0] out_idx,
  output logic          empty
);
  logic [LAT-1:0] v;
  logic [LAT-1:0] en;
  logic [IW-1:0]  idx [LAT];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v  <= '0;
      en <= '0;
      for (int i = 0; i < LAT; i++)
        idx[i] <= '0;
    end else begin
      v[0]   <= in_v;
      en[0]  <= in_v & in_en;
      idx[0] <= in_idx;
      for (int i = 1; i < LAT; i++) begin
        v[i]   <= v[i-1];
        en[i]  <= en[i-1];
        idx[i] <= idx[i-1];
      end
    end
  end

  assign out_v   = v[LAT-1];
  assign out_en  = en[LAT-1];
  assign out_idx = idx[LAT-1];
  assign empty   = ~|v;
endmodule

// File: rtl/sprite_line_loader.sv
// Per-line sprite image loader: walks sprite ROM addresses, strobes loads.
// Define SPR_SKIP_EN to skip inactive sprites during the address walk.
module sprite_line_loader
  import sprite_pkg::*;
#(
  parameter int NUM_SPR = 5,
  parameter int ADDR_W  = 9,
  parameter int MEM_LAT = 1
) (
  input logic clk,
  input logic rst,
  sprite_line_loader_if.slave bus
);
  localparam int IW = spr_idx_w(NUM_SPR);

  state_t state, state_nx;

  logic [IW-1:0]      idx;
  logic [NUM_SPR-1:0] mask;
  logic               loc_d;
  logic               start;
  logic               start_q;
  logic               push;
  logic               abort;
  logic               fin;
  logic               first_v;
  logic [IW-1:0]      first_idx;
  logic               next_v;
  logic [IW-1:0]      next_idx;
  logic               p_v;
  logic               p_en;
  logic [IW-1:0]      p_idx;
  logic               p_empty;

  assign start = !bus.loading_loc &
                 (bus.linebegin | (loc_d & ~bus.loading_loc));

`ifdef SPR_SKIP_EN
  always_comb begin
    first_v   = 1'b0;
    first_idx = '0;
    next_v    = 1'b0;
    next_idx  = '0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first_v   = 1'b1;
        first_idx = IW'(i);
      end
      if (mask[i] && (i > int'(idx))) begin
        next_v   = 1'b1;
        next_idx = IW'(i);
      end
    end
  end
`else
  localparam logic [IW-1:0] LAST = IW'(NUM_SPR - 1);

  always_comb begin
    first_v   = 1'b1;
    first_idx = '0;
    next_v    = (idx != LAST);
    next_idx  = idx + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (start_q && !bus.loading_loc)
          state_nx = first_v ? ISSUE : DRAIN;
      ISSUE:
        if (bus.loading_loc) state_nx = IDLE;
        else if (!next_v)    state_nx = DRAIN;
      DRAIN:
        if (bus.loading_loc || p_empty)
          state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    push     = (state == ISSUE) && !bus.loading_loc;
    abort    = (state != IDLE) && bus.loading_loc;
    fin      = (state == DRAIN) && !bus.loading_loc && p_empty;
    bus.busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx               <= '0;
      mask              <= '0;
      loc_d             <= 1'b0;
      start_q           <= 1'b0;
      bus.mem_addr_out  <= '0;
      bus.load_en       <= '0;
      bus.img_load_done <= 1'b0;
    end else begin
      loc_d             <= bus.loading_loc;
      bus.img_load_done <= fin;
      bus.mem_addr_out  <= push ?
        bus.mem_addr_flat[int'(idx)*ADDR_W +: ADDR_W] : '0;
      bus.load_en <= (!abort && p_v && p_en) ?
        (NUM_SPR'(1) << p_idx) : '0;
      if (state == IDLE) begin
        // Start is registered one cycle so the mask settles before the walk
        if (start_q) begin
          start_q <= 1'b0;
          idx     <= first_idx;
        end else if (start) begin
          start_q <= 1'b1;
          mask    <= bus.spr_active;
          idx     <= '0;
        end
      end else begin
        start_q <= 1'b0;
        if (push && next_v) idx <= next_idx;
      end
    end
  end

  spr_lat_pipe #(
    .LAT (MEM_LAT),
    .IW  (IW)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .flush   (abort),
    .in_v    (push),
    .in_en   (mask[idx]),
    .in_idx  (idx),
    .out_v   (p_v),
    .out_en  (p_en),
    .out_idx (p_idx),
    .empty   (p_empty)
  );
endmodule
